// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory initiator: data width,
// access-size codes, FSM state encodings and a size-to-alignment-mask helper.
package mem_access_ctrl_pkg;

  localparam int WORD = 64;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    MA_IDLE = 3'd0,
    MA_RD   = 3'd1,
    MA_CAP  = 3'd2,
    MA_WR   = 3'd3,
    MA_RESP = 3'd4
  } ma_state_e;

  // Low address bits that must be zero for a naturally aligned access (bytes-1).
  function automatic logic [2:0] size_low_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for the data-memory initiator: extracts and
// sign/zero-extends a load lane from a dword, and inserts store data into a
// dword for read-modify-write.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int DW = WORD
) (
  input  logic [1:0]    size_i,
  input  logic [2:0]    off_i,
  input  logic          signed_i,
  input  logic [DW-1:0] dword_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] load_o,
  output logic [DW-1:0] merged_o
);

  logic [5:0]    sh_s;
  logic [DW-1:0] lane_s;
  logic [DW-1:0] lane_mask_s;

  assign sh_s   = {off_i, 3'b000};
  assign lane_s = dword_i >> sh_s;

  // Select the lane width and build the extended load value for the access size.
  always_comb begin
    lane_mask_s = {DW{1'b1}};
    load_o      = lane_s;
    case (size_i)
      SZ_B: begin
        lane_mask_s = {{(DW-8){1'b0}}, 8'hFF};
        load_o      = {{(DW-8){signed_i & lane_s[7]}}, lane_s[7:0]};
      end
      SZ_H: begin
        lane_mask_s = {{(DW-16){1'b0}}, 16'hFFFF};
        load_o      = {{(DW-16){signed_i & lane_s[15]}}, lane_s[15:0]};
      end
      SZ_W: begin
        lane_mask_s = {{(DW-32){1'b0}}, 32'hFFFF_FFFF};
        load_o      = {{(DW-32){signed_i & lane_s[31]}}, lane_s[31:0]};
      end
      default: begin
        lane_mask_s = {DW{1'b1}};
        load_o      = lane_s;
      end
    endcase
  end

  assign merged_o = (dword_i & ~(lane_mask_s << sh_s)) | ((wdata_i & lane_mask_s) << sh_s);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator. Turns one load/store request into registered
// mem_read/mem_write cycles, using read-modify-write for sub-dword stores since
// the memory has no byte strobes. Optional misalignment fault: ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DW = WORD,
  parameter int AW = 64
) (
  input  logic          im_clk,
  input  logic          im_rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  ma_state_e     state_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [2:0]    off_q;
  logic [DW-1:0] wdata_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          resp_valid_q;
  logic [DW-1:0] resp_rdata_q;

  logic [2:0]    off_d;
  logic [DW-1:0] load_d;
  logic [DW-1:0] merged_d;

  // Lane offset: low address bits with the sub-size bits masked off.
  assign off_d = req_addr[2:0] & ~size_low_mask(req_size);

`ifdef ALIGN_CHECK_EN
  logic resp_err_q;
  logic misalign_d;
  assign misalign_d = (req_addr[2:0] & size_low_mask(req_size)) != 3'b000;
  assign resp_err   = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Ready is combinational on reset so it rises the moment reset releases.
  assign req_ready  = im_rst_n & (state_q == MA_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  mem_lane_align #(.DW(DW)) u_lane (
    .size_i   (size_q),
    .off_i    (off_q),
    .signed_i (signed_q),
    .dword_i  (mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_d),
    .merged_o (merged_d)
  );

  // Access sequencer: state, latched request and all registered outputs.
  always_ff @(posedge im_clk or negedge im_rst_n) begin
    if (!im_rst_n) begin
      state_q      <= MA_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 3'b000;
      wdata_q      <= {DW{1'b0}};
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DW{1'b0}};
`ifdef ALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        MA_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            signed_q   <= req_signed;
            off_q      <= off_d;
            wdata_q    <= req_wdata;
            mem_addr_q <= {req_addr[AW-1:3], 3'b000};
`ifdef ALIGN_CHECK_EN
            if (misalign_d) begin
              state_q      <= MA_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= {DW{1'b0}};
            end else
`endif
            if (req_write && (req_size == SZ_D)) begin
              state_q     <= MA_WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= MA_RD;
              mem_read_q <= 1'b1;
            end
          end else begin
            state_q <= MA_IDLE;
          end
        end
        MA_RD: begin
          mem_read_q <= 1'b0;
          state_q    <= MA_CAP;
        end
        MA_CAP: begin
          if (write_q) begin
            mem_wdata_q <= merged_d;
            mem_write_q <= 1'b1;
            state_q     <= MA_WR;
          end else begin
            resp_rdata_q <= load_d;
            resp_valid_q <= 1'b1;
            state_q      <= MA_RESP;
          end
        end
        MA_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= {DW{1'b0}};
          state_q      <= MA_RESP;
        end
        MA_RESP: begin
          resp_valid_q <= 1'b0;
`ifdef ALIGN_CHECK_EN
          resp_err_q   <= 1'b0;
`endif
          state_q      <= MA_IDLE;
        end
        default: begin
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= MA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses against a byte-level reference model and a 32-dword memory model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        im_clk = 1'b0;
  logic        im_rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_read, mem_write;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int both_cnt = 0;
  int wr_total = 0;

  logic [63:0] mem [0:31];
  logic [63:0] ref_mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [63:0] pl_data = 64'd0;

  // results of the most recent access
  int          r_lat, r_nrd, r_nwr, r_abad, r_brdy, r_waits;
  logic [63:0] r_rd, r_wseen;
  logic        r_err, r_tmo;

  always #5 im_clk = ~im_clk;

  mem_access_ctrl dut (
    .im_clk(im_clk), .im_rst_n(im_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // data_mem model: data valid one cycle after a read cycle, X otherwise
  always @(posedge im_clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[7:3]];
    else mem_rdata <= 'x;
  end

  always @(negedge im_clk) begin
    if (mem_read && mem_write) both_cnt++;
    if (mem_write) wr_total++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [1:0] sz,
                                           input logic sg, input logic [63:0] a);
    int n = 1 << sz;
    int off = int'(a[2:0]) & ~(n - 1);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (sg && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] d, input logic [1:0] sz,
                                            input logic [63:0] a, input logic [63:0] w);
    int n = 1 << sz;
    int off = int'(a[2:0]) & ~(n - 1);
    logic [63:0] v = d;
    for (int i = 0; i < n; i++) v[8*(off+i) +: 8] = w[8*i +: 8];
    return v;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [63:0] a);
`ifdef ALIGN_CHECK_EN
    int n = 1 << sz;
    return (int'(a[2:0]) % n) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic preload(input int idx, input logic [63:0] val);
    pl_en = 1'b1; pl_idx = idx[4:0]; pl_data = val;
    @(posedge im_clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
    @(negedge im_clk);
  endtask

  // Issue one request (called at a negedge); returns at the negedge where resp_valid is seen.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [63:0] a, input logic [63:0] wd, input logic hold);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_abad = 0; r_brdy = 0; r_waits = 0;
    r_rd = 64'd0; r_wseen = 64'd0; r_err = 1'b0; r_tmo = 1'b0;
    while (req_ready !== 1'b1 && r_waits < 20) begin
      @(negedge im_clk); r_waits++;
    end
    if (req_ready !== 1'b1) begin
      r_tmo = 1'b1; req_valid = 1'b0;
      return;
    end
    @(posedge im_clk);
    do begin
      @(negedge im_clk);
      r_lat++;
      if (!hold) req_valid = 1'b0;
      if (req_ready === 1'b1) r_brdy++;
      if (mem_read === 1'b1) begin
        r_nrd++;
        if (mem_addr !== {a[63:3], 3'b000}) r_abad++;
      end
      if (mem_write === 1'b1) begin
        r_nwr++; r_wseen = mem_wdata;
        if (mem_addr !== {a[63:3], 3'b000}) r_abad++;
      end
    end while (resp_valid !== 1'b1 && r_lat < 20);
    if (resp_valid !== 1'b1) r_tmo = 1'b1;
    r_rd = resp_rdata; r_err = resp_err;
  endtask

  task automatic test_reset();
    im_rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    #12;
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 ||
        resp_rdata !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: ctrl=%b rdata=%h addr=%h wdata=%h, required all 0",
               {req_ready, resp_valid, resp_err, mem_read, mem_write}, resp_rdata, mem_addr, mem_wdata);
    end
    @(negedge im_clk); im_rst_n = 1'b1; #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
    @(negedge im_clk);
  endtask

  task automatic test_dword_store();
    do_access(1'b1, SZ_D, 1'b0, 64'h10, 64'h1122334455667788, 1'b0);
    tests++;
    if (r_tmo || r_lat != 2 || r_nrd != 0 || r_nwr != 1 || r_abad != 0) begin
      fails++; $display("FAIL dword_store_seq: tmo=%b lat=%0d rd=%0d wr=%0d abad=%0d, required 0/2/0/1/0",
                        r_tmo, r_lat, r_nrd, r_nwr, r_abad);
    end
    tests++;
    if (r_wseen !== 64'h1122334455667788 || mem[2] !== 64'h1122334455667788 || r_rd !== 64'd0) begin
      fails++; $display("FAIL dword_store_data: wdata=%h mem=%h rdata=%h, required 1122334455667788/same/0",
                        r_wseen, mem[2], r_rd);
    end
    ref_mem[2] = 64'h1122334455667788;
  endtask

  task automatic test_byte_load();
    preload(2, 64'h0000_0000_8000_0000);
    do_access(1'b0, SZ_B, 1'b1, 64'h13, 64'd0, 1'b0);
    tests++;
    if (r_tmo || r_lat != 3 || r_nrd != 1 || r_nwr != 0 || r_rd !== 64'hFFFF_FFFF_FFFF_FF80) begin
      fails++; $display("FAIL byte_load_signed: tmo=%b lat=%0d rd=%0d wr=%0d data=%h, required 0/3/1/0/ffffffffffffff80",
                        r_tmo, r_lat, r_nrd, r_nwr, r_rd);
    end
    do_access(1'b0, SZ_B, 1'b0, 64'h13, 64'd0, 1'b0);
    tests++;
    if (r_tmo || r_rd !== 64'h80) begin
      fails++; $display("FAIL byte_load_unsigned: tmo=%b data=%h, required 0/80", r_tmo, r_rd);
    end
    @(negedge im_clk);
    tests++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'h80) begin
      fails++; $display("FAIL resp_hold: valid=%b data=%h, required 0/80", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_byte_store();
    preload(1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_access(1'b1, SZ_B, 1'b0, 64'h0A, 64'h0123_4567_89AB_CDAB, 1'b0);
    tests++;
    if (r_tmo || r_lat != 4 || r_nrd != 1 || r_nwr != 1 || r_abad != 0) begin
      fails++; $display("FAIL byte_store_seq: tmo=%b lat=%0d rd=%0d wr=%0d abad=%0d, required 0/4/1/1/0",
                        r_tmo, r_lat, r_nrd, r_nwr, r_abad);
    end
    tests++;
    if (r_wseen !== 64'hFFFF_FFFF_FFAB_FFFF || mem[1] !== 64'hFFFF_FFFF_FFAB_FFFF || r_rd !== 64'd0) begin
      fails++; $display("FAIL byte_store_data: wdata=%h mem=%h rdata=%h, required ffffffffffabffff/same/0",
                        r_wseen, mem[1], r_rd);
    end
    ref_mem[1] = 64'hFFFF_FFFF_FFAB_FFFF;
  endtask

  task automatic test_reset_mid_op();
    int wr_before;
    preload(3, 64'hA5A5_5A5A_0F0F_F0F0);
    wr_before = wr_total;
    req_write = 1'b1; req_size = SZ_B; req_signed = 1'b0; req_addr = 64'h19;
    req_wdata = 64'h77; req_valid = 1'b1;
    @(posedge im_clk);
    @(negedge im_clk);
    tests++;
    if (mem_read !== 1'b1) begin
      fails++; $display("FAIL rst_mid_rd_cycle: mem_read=%b, required 1", mem_read);
    end
    im_rst_n = 1'b0; req_valid = 1'b0; #1;
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 ||
        mem_addr !== 64'd0 || mem_wdata !== 64'd0 || resp_rdata !== 64'd0) begin
      fails++; $display("FAIL rst_mid_outputs: ctrl=%b addr=%h, required all 0",
                        {req_ready, resp_valid, resp_err, mem_read, mem_write}, mem_addr);
    end
    repeat (3) @(negedge im_clk);
    tests++;
    if (wr_total != wr_before || mem[3] !== ref_mem[3]) begin
      fails++; $display("FAIL rst_mid_memory: writes=%0d mem=%h, required %0d/%h",
                        wr_total, mem[3], wr_before, ref_mem[3]);
    end
    im_rst_n = 1'b1; #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_ready: req_ready=%b, required 1", req_ready);
    end
    @(negedge im_clk);
  endtask

  task automatic test_back_to_back();
    int lat1, brdy1;
    logic [63:0] rd1, e1, e2;
    e1 = ref_load(ref_mem[4], SZ_D, 1'b0, 64'h20);
    e2 = ref_load(ref_mem[5], SZ_W, 1'b1, 64'h2C);
    do_access(1'b0, SZ_D, 1'b0, 64'h20, 64'd0, 1'b1);
    lat1 = r_lat; brdy1 = r_brdy; rd1 = r_rd;
    tests++;
    if (r_tmo || lat1 != 3 || brdy1 != 0 || rd1 !== e1) begin
      fails++; $display("FAIL b2b_first: tmo=%b lat=%0d ready_busy=%0d data=%h, required 0/3/0/%h",
                        r_tmo, lat1, brdy1, rd1, e1);
    end
    do_access(1'b0, SZ_W, 1'b1, 64'h2C, 64'd0, 1'b0);
    tests++;
    if (r_tmo || r_waits != 1 || r_lat != 3 || r_brdy != 0 || r_rd !== e2) begin
      fails++; $display("FAIL b2b_second: tmo=%b waits=%0d lat=%0d ready_busy=%0d data=%h, required 0/1/3/0/%h",
                        r_tmo, r_waits, r_lat, r_brdy, r_rd, e2);
    end
  endtask

  task automatic test_misalign();
    logic [63:0] exp_d;
    do_access(1'b0, SZ_H, 1'b0, 64'h05, 64'd0, 1'b0);
`ifdef ALIGN_CHECK_EN
    exp_d = 64'd0;
    tests++;
    if (r_tmo || r_lat != 1 || r_nrd != 0 || r_nwr != 0 || r_err !== 1'b1 || r_rd !== exp_d) begin
      fails++; $display("FAIL misalign_fault: tmo=%b lat=%0d rd=%0d wr=%0d err=%b data=%h, required 0/1/0/0/1/0",
                        r_tmo, r_lat, r_nrd, r_nwr, r_err, r_rd);
    end
`else
    exp_d = {48'd0, ref_mem[0][47:32]};
    tests++;
    if (r_tmo || r_lat != 3 || r_nrd != 1 || r_err !== 1'b0 || r_rd !== exp_d) begin
      fails++; $display("FAIL misalign_masked: tmo=%b lat=%0d rd=%0d err=%b data=%h, required 0/3/1/0/%h",
                        r_tmo, r_lat, r_nrd, r_err, r_rd, exp_d);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic w, sg, mis;
      logic [1:0] sz;
      logic [63:0] a, wd, exp_rd, exp_mem;
      int idx, exp_lat, exp_rd_n, exp_wr_n;
      w = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom}; wd = {$urandom, $urandom};
      idx = int'(a[7:3]);
      mis = ref_misaligned(sz, a);
      exp_mem = ref_mem[idx];
      exp_rd = 64'd0;
      if (mis) begin exp_lat = 1; exp_rd_n = 0; exp_wr_n = 0; end
      else if (!w) begin exp_lat = 3; exp_rd_n = 1; exp_wr_n = 0; exp_rd = ref_load(exp_mem, sz, sg, a); end
      else if (sz == SZ_D) begin exp_lat = 2; exp_rd_n = 0; exp_wr_n = 1; exp_mem = ref_store(exp_mem, sz, a, wd); end
      else begin exp_lat = 4; exp_rd_n = 1; exp_wr_n = 1; exp_mem = ref_store(exp_mem, sz, a, wd); end
      do_access(w, sz, sg, a, wd, 1'b0);
      tests++;
      if (r_tmo || r_lat != exp_lat || r_nrd != exp_rd_n || r_nwr != exp_wr_n || r_abad != 0 || r_brdy != 0) begin
        fails++; $display("FAIL rand_seq[%0d]: tmo=%b lat=%0d rd=%0d wr=%0d abad=%0d rdy=%0d, required 0/%0d/%0d/%0d/0/0",
                          it, r_tmo, r_lat, r_nrd, r_nwr, r_abad, r_brdy, exp_lat, exp_rd_n, exp_wr_n);
      end
      tests++;
      if (r_rd !== exp_rd || r_err !== mis || mem[idx] !== exp_mem) begin
        fails++; $display("FAIL rand_data[%0d]: data=%h err=%b mem=%h, required %h/%b/%h",
                          it, r_rd, r_err, mem[idx], exp_rd, mis, exp_mem);
      end
      ref_mem[idx] = exp_mem;
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
    test_dword_store();
    test_byte_load();
    test_byte_store();
    test_reset_mid_op();
    test_back_to_back();
    test_misalign();
    test_random();
    tests++;
    if (both_cnt != 0) begin
      fails++; $display("FAIL strobe_exclusive: both-high cycles=%0d, required 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
